// File: rtl/lfs_pkg.sv
// Shared types and constants for the layer fetch sequencer.
// Sequencer states, burst geometry and the input-count clamp.
package lfs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    GAP,
    PRESENT,
    FIN
  } lfs_state_t;

  localparam int LFS_K_PER_BURST = 4;
  localparam int LFS_MAX_INPUTS  = 4;

  // A layer never has more inputs than the memory's input select can address
  function automatic logic [2:0] lfs_clamp_inputs(input logic [2:0] num);
    return (num > 3'(LFS_MAX_INPUTS)) ? 3'(LFS_MAX_INPUTS) : num;
  endfunction

endpackage

// File: rtl/lfs_capture_buf.sv
// Four-slot word register bank filled one word per write from a memory burst.
// The packed output holds slot k at bits [k*DW +: DW].
module lfs_capture_buf
  import lfs_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [1:0]                   slot,
  input  logic [DW-1:0]                wr_data,
  output logic [LFS_K_PER_BURST*DW-1:0] words
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words <= '0;
    end else if (wr_en) begin
      words[int'(slot)*DW +: DW] <= wr_data;
    end
  end

endmodule

// File: rtl/layer_fetch_seq.sv
// Read-side sequencer: bursts one layer's weights/biases out of memory and presents
// per-input weight vectors over valid/ready. Optional out_zero flag: LFS_ZERO_SKIP_EN.
module layer_fetch_seq
  import lfs_pkg::*;
#(
  parameter int DW          = 16,
  parameter int K_PER_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      layer,
  input  logic [2:0]      num_inputs,
  output logic            busy,
  output logic            done,
  output logic            weight_en,
  output logic            bias_en,
  output logic [5:0]      n,
  output logic [5:0]      i,
  input  logic [DW-1:0]   wt_data,
  input  logic [DW-1:0]   bias_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_idx,
  output logic [4*DW-1:0] out_w,
  output logic [4*DW-1:0] out_bias,
  output logic            bias_valid
`ifdef LFS_ZERO_SKIP_EN
  ,
  output logic            out_zero
`endif
);

  localparam logic [1:0] LAST_BEAT = 2'(K_PER_BURST - 1);

  lfs_state_t state, state_next;

  logic [5:0] layer_q;
  logic [2:0] num_q;
  logic [2:0] num_clamped;
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic [1:0] beat;
  logic [1:0] beat_d;
  logic       wcap_d;
  logic       bcap_d;

  assign num_clamped = lfs_clamp_inputs(num_inputs);
  assign idx_next    = idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_clamped == 3'd0) ? FIN : BURST;
        end
      end
      BURST: begin
        if (beat == LAST_BEAT) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          state_next = (idx_next == num_q) ? FIN : BURST;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory data lags its enable by one edge, so capture uses last cycle's beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q    <= '0;
      num_q      <= '0;
      idx        <= '0;
      beat       <= '0;
      beat_d     <= '0;
      wcap_d     <= 1'b0;
      bcap_d     <= 1'b0;
      bias_valid <= 1'b0;
    end else begin
      wcap_d <= weight_en;
      bcap_d <= bias_en;
      beat_d <= beat;
      unique case (state)
        IDLE: begin
          if (start) begin
            layer_q <= layer;
            num_q   <= num_clamped;
            idx     <= '0;
            beat    <= '0;
          end
        end
        BURST: begin
          beat <= beat + 2'd1;
        end
        GAP: begin
          if (idx == 3'd0) begin
            bias_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            idx  <= idx_next;
            beat <= '0;
            if (idx_next == num_q) begin
              bias_valid <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state == BURST) || (state == GAP) || (state == PRESENT);
  assign done      = (state == FIN);
  assign weight_en = (state == BURST);
  assign bias_en   = weight_en && (idx == 3'd0);
  assign n         = layer_q;
  assign i         = weight_en ? {3'b000, idx} : 6'd0;
  assign out_valid = (state == PRESENT);
  assign out_idx   = idx[1:0];

  lfs_capture_buf #(.DW(DW)) u_wt_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wcap_d),
    .slot    (beat_d),
    .wr_data (wt_data),
    .words   (out_w)
  );

  lfs_capture_buf #(.DW(DW)) u_bias_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bcap_d),
    .slot    (beat_d),
    .wr_data (bias_data),
    .words   (out_bias)
  );

`ifdef LFS_ZERO_SKIP_EN
  assign out_zero = out_valid && (out_w == '0);
`endif

endmodule

// File: doc/layer_fetch_seq.md
# layer_fetch_seq

Read-side sequencer for the weight/bias memory. On `start` it walks one layer's input index `i`, drives the memory's `weight_en`/`bias_en` bursts, and captures the 4 auto-incremented weight words per input plus the layer's 4 bias words. It presents each input's 4-weight vector to the MAC array over a valid/ready handshake. It sits between the layer controller and the CORDIC MAC datapath, and is the only agent driving the memory's `n`, `i` and enable pins.

## Interface
Parameters:
- `DW`, 16, weight/bias word width (Q-format unchanged, passed through).
- `K_PER_BURST`, 4, words per burst; matches the memory's 2-bit auto-increment `k`.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `layer`  in  6  layer index; latched at `start`, driven on `n`.
- `num_inputs`  in  3  input count for the layer; latched at `start`.
- `busy`  out  1  high from the `start` edge until `done`.
- `done`  out  1  one-cycle pulse when the layer is finished.
- `weight_en`  out  1  memory weight read enable.
- `bias_en`  out  1  memory bias read enable.
- `n`  out  6  memory layer select (the memory uses `n[2:0]`).
- `i`  out  6  memory input select (the memory uses `i[1:0]`).
- `wt_data`  in  DW  memory weight word; registered by the memory one edge after the enable.
- `bias_data`  in  DW  memory bias word; same timing as `wt_data`.
- `out_valid`  out  1  weight vector available.
- `out_ready`  in  1  MAC accepts the vector.
- `out_idx`  out  2  input index of the presented vector.
- `out_w`  out  4*DW  weights; word k occupies bits `[k*DW +: DW]`.
- `out_bias`  out  4*DW  biases; same packing as `out_w`.
- `bias_valid`  out  1  `out_bias` holds the current layer's biases.

## Operation
- States: IDLE, BURST, GAP, PRESENT, FIN.
- **IDLE**
  - On `start`: latch `layer` and `num_inputs`; clear the input counter and beat counter.
  - `num_inputs` 0: go to FIN with no memory access.
  - `num_inputs` 5–7: clamp to 4.
  - Any other value: go to BURST.
- **BURST**
  - Lasts exactly 4 cycles with `weight_en`=1 and `i` = current input index.
  - The memory's `k` steps 0..3 across these cycles.
  - `bias_en` mirrors `weight_en` during the first burst (input 0) only.
  - Then go to GAP.
- **GAP**
  - 1 cycle with `weight_en`=0 and `bias_en`=0, so the memory's `k` returns to 0.
  - The last word is captured in this cycle.
  - Then go to PRESENT.
- **Capture**
  - Each word read at an enable edge appears on `wt_data` after that edge and is stored at the next edge into slot = beat counter delayed one cycle.
  - Bias slots are filled the same way during the first burst.
- **PRESENT**
  - `out_valid`=1. `out_w`, `out_idx`, `out_bias` and `bias_valid` are stable until the handshake.
  - On `out_valid && out_ready`: increment the input index. If it reaches `num_inputs`, go to FIN; otherwise go to BURST.
- **FIN**
  - 1 cycle: `done`=1, `busy` deasserts, `bias_valid` clears.
  - Then go to IDLE.
- `start` is not queued. A `start` pulse seen while `busy` is dropped.
- `n` holds the latched `layer` for the whole operation. `i` holds the index during BURST and is 0 in IDLE.

## Timing
- Reset values:
  - `busy`, `done`, `weight_en`, `bias_en`, `out_valid`, `bias_valid` = 0.
  - `n`, `i`, `out_idx`, `out_w`, `out_bias` = 0.
  - State = IDLE.
- `start` is sampled at edge E0. `weight_en` is high for the edges E1..E4. Words are captured at E2..E5. `out_valid` rises after E5.
- Per-input latency from the handshake edge to the next `out_valid`: 5 edges (4 BURST + 1 GAP).
- A layer with `num_inputs`=N with `out_ready` tied high completes in 6N+1 cycles from the `start` edge to the `done` pulse.
- `weight_en` is never high for more than 4 consecutive cycles. There are always at least 2 low cycles between bursts (GAP + PRESENT).
- Reset mid-operation:
  - `weight_en` and `bias_en` drop asynchronously.
  - Partial captures are discarded.
  - No `done` is produced.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `LFS_ZERO_SKIP_EN` defined:
  - Adds output `out_zero` (1 bit). It is high with `out_valid` when all 4 words of `out_w` are 0.
  - The MAC may skip that input. Handshake timing is unchanged.
- `LFS_ZERO_SKIP_EN` undefined:
  - The port is absent. No comparator is built.

## Structure
- Package `lfs_pkg` holds:
  - the state enum: IDLE, BURST, GAP, PRESENT, FIN;
  - `LFS_K_PER_BURST`=4;
  - `LFS_MAX_INPUTS`=4.
- One sub-module: `lfs_capture_buf`.
  - A 4-slot DW register bank with a write enable and a 2-bit slot index.
  - Instantiated twice: once for weights, once for biases.

## Test plan
- **Basic layer:** memory preloaded for layer 0 as 0x0040, 0x0080, 0, 0 per input; biases 0x0078, 0x0059, 0, 0; `num_inputs`=2; `out_ready`=1.
  - Expect 2 vectors with `out_idx` 0 and 1.
  - Expect `out_bias` = {0, 0, 0x0059, 0x0078}, `bias_valid`=1.
  - Expect `done` 13 cycles after `start`.
- **Backpressure:** hold `out_ready`=0 for 7 cycles in PRESENT.
  - `out_w` stays stable.
  - `weight_en` stays 0.
  - The next burst starts the cycle after `out_ready` rises.
- **Enable spacing:** `num_inputs`=4.
  - Monitor asserts `weight_en` runs of exactly 4 cycles, separated by at least 2 low cycles.
  - `bias_en` is high only in the first run.
- **Edge counts:**
  - `num_inputs`=0: `done` 1 cycle after `start`; `weight_en` never asserts.
  - `num_inputs`=7: exactly 4 vectors.
- **Reset and dropped start:**
  - Assert `rst` during the 3rd BURST cycle: `weight_en`=0 immediately and all outputs return to reset values.
  - A `start` pulse while `busy` is ignored.
- **Zero skip (with `LFS_ZERO_SKIP_EN`):** layer 1, input 1 all zeros.
  - `out_zero`=1 for `out_idx`=1 only.
